frame_renderer: RTL and testbench

- Upstream pixel source for the VGA adapter path in the car game.
- On each start pulse it sweeps the full 160x120 frame in raster order.
- For each pixel it reads colour from an external background ROM, with the row index shifted by a latched scroll offset.
- It emits one x/y/colour/plot beat per cycle, so the scrolling road is redrawn as a full frame instead of by remapping y per pixel.

---
 rtl/frame_pkg.sv | 28 ++
 rtl/raster_counter.sv | 53 +++++
 rtl/frame_renderer.sv | 162 ++++++++++++++++
 tb/tb_frame_renderer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/frame_pkg.sv
// Shared constants, state encoding and helpers for the frame rendering path.
package frame_pkg;

    localparam int unsigned XSCREEN      = 160;
    localparam int unsigned YSCREEN      = 120;
    localparam int unsigned COLOUR_W     = 3;
    localparam int unsigned ADDR_W       = 15;
    localparam int unsigned FRAME_PIXELS = XSCREEN * YSCREEN;
    localparam int unsigned X_W          = 8;
    localparam int unsigned Y_W          = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // Fold a row sum back into 0..YSCREEN-1 with a single conditional subtract.
    function automatic logic [Y_W-1:0] wrap_row(input logic [Y_W:0] sum);
        logic [Y_W:0] folded;
        folded = sum;
        if (sum >= (Y_W+1)'(YSCREEN)) begin
            folded = sum - (Y_W+1)'(YSCREEN);
        end
        return folded[Y_W-1:0];
    endfunction

endpackage

// File: rtl/raster_counter.sv
// Raster-order column/row counter with offset-wrapped source row.
module raster_counter
    import frame_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic           clear,
    input  logic           advance,
    input  logic [Y_W-1:0] offset,
    output logic [X_W-1:0] cx,
    output logic [Y_W-1:0] cy,
    output logic           last_pixel,
    output logic [Y_W-1:0] src_y
);

    logic [X_W-1:0] cx_q, cx_d;
    logic [Y_W-1:0] cy_q, cy_d;
    logic           row_end;

    assign row_end = (cx_q == X_W'(XSCREEN - 1));

    always_comb begin
        cx_d = cx_q;
        cy_d = cy_q;
        if (clear) begin
            cx_d = '0;
            cy_d = '0;
        end else if (advance) begin
            if (row_end) begin
                cx_d = '0;
                cy_d = (cy_q == Y_W'(YSCREEN - 1)) ? '0 : cy_q + Y_W'(1);
            end else begin
                cx_d = cx_q + X_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cx_q <= '0;
            cy_q <= '0;
        end else begin
            cx_q <= cx_d;
            cy_q <= cy_d;
        end
    end

    assign cx         = cx_q;
    assign cy         = cy_q;
    assign last_pixel = row_end && (cy_q == Y_W'(YSCREEN - 1));
    assign src_y      = wrap_row({1'b0, cy_q} + {1'b0, offset});

endmodule

// File: rtl/frame_renderer.sv
// Sweeps the full frame in raster order, reading a scrolled background ROM
// and emitting one x/y/colour/plot beat per cycle.
module frame_renderer
    import frame_pkg::*;
(
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic                start,
    input  logic [6:0]          scroll_offset,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [COLOUR_W-1:0] rom_data,
    output logic [7:0]          x,
    output logic [6:0]          y,
    output logic [COLOUR_W-1:0] colour,
    output logic                plot,
    output logic                busy,
    output logic                done
);

    state_t state_q, state_d;

    logic [Y_W-1:0]      off_q, off_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    // Stage 1: pixel whose address is at the ROM this cycle.
    logic                p1_vld_q, p1_vld_d;
    logic [X_W-1:0]      p1_x_q, p1_x_d;
    logic [Y_W-1:0]      p1_y_q, p1_y_d;
    logic                p1_last_q, p1_last_d;

    // Stage 2: registered adapter outputs.
    logic                plot_q, plot_d;
    logic [X_W-1:0]      x_q, x_d;
    logic [Y_W-1:0]      y_q, y_d;
    logic [COLOUR_W-1:0] colour_q, colour_d;
    logic                out_last_q, out_last_d;

    logic                cnt_clear;
    logic                cnt_advance;
    logic [X_W-1:0]      cx;
    logic [Y_W-1:0]      cy;
    logic                last_pixel;
    logic [Y_W-1:0]      src_y;
    logic [Y_W-1:0]      latched_off;

    raster_counter u_raster (
        .clk        (CLOCK_50),
        .reset      (reset),
        .clear      (cnt_clear),
        .advance    (cnt_advance),
        .offset     (off_q),
        .cx         (cx),
        .cy         (cy),
        .last_pixel (last_pixel),
        .src_y      (src_y)
    );

    // Counters and offset register are zero after reset, so this is 0 too.
    assign rom_addr = ADDR_W'(src_y) * ADDR_W'(XSCREEN) + ADDR_W'(cx);

    assign latched_off = (scroll_offset >= Y_W'(YSCREEN)) ?
                         scroll_offset - Y_W'(YSCREEN) : scroll_offset;

    always_comb begin
        state_d     = state_q;
        off_d       = off_q;
        busy_d      = busy_q;
        done_d      = out_last_q;
        cnt_clear   = 1'b0;
        cnt_advance = 1'b0;

        p1_vld_d    = 1'b0;
        p1_x_d      = p1_x_q;
        p1_y_d      = p1_y_q;
        p1_last_d   = 1'b0;

        plot_d      = p1_vld_q;
        x_d         = x_q;
        y_d         = y_q;
        colour_d    = colour_q;
        out_last_d  = p1_vld_q && p1_last_q;

        if (p1_vld_q) begin
            x_d      = p1_x_q;
            y_d      = p1_y_q;
            colour_d = rom_data;
        end

        // busy stays high through the final plot beat; it drops with done.
        if (out_last_q) begin
            busy_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (start && !busy_q) begin
                    off_d     = latched_off;
                    cnt_clear = 1'b1;
                    busy_d    = 1'b1;
                    state_d   = SWEEP;
                end
            end
            SWEEP: begin
                p1_vld_d    = 1'b1;
                p1_x_d      = cx;
                p1_y_d      = cy;
                p1_last_d   = last_pixel;
                cnt_advance = !last_pixel;
                if (last_pixel) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q    <= IDLE;
            off_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            p1_vld_q   <= 1'b0;
            p1_x_q     <= '0;
            p1_y_q     <= '0;
            p1_last_q  <= 1'b0;
            plot_q     <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            colour_q   <= '0;
            out_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            off_q      <= off_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            p1_vld_q   <= p1_vld_d;
            p1_x_q     <= p1_x_d;
            p1_y_q     <= p1_y_d;
            p1_last_q  <= p1_last_d;
            plot_q     <= plot_d;
            x_q        <= x_d;
            y_q        <= y_d;
            colour_q   <= colour_d;
            out_last_q <= out_last_d;
        end
    end

    assign x      = x_q;
    assign y      = y_q;
    assign colour = colour_q;
    assign plot   = plot_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_frame_renderer.sv
// Scoreboard bench for frame_renderer with a registered 1-cycle ROM model.
module tb_frame_renderer;

    localparam int unsigned XS = 160;
    localparam int unsigned YS = 120;
    localparam int unsigned NPIX = XS * YS;

    typedef struct packed {
        logic [7:0]  x;
        logic [6:0]  y;
        logic [14:0] addr;
        logic [2:0]  colour;
        logic        last;
    } pix_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [6:0]  scroll_offset = '0;
    logic [14:0] rom_addr;
    logic [2:0]  rom_data = '0;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        plot;
    logic        busy;
    logic        done;

    logic [14:0] rom_a1 = '0;
    logic [14:0] rom_a2 = '0;

    pix_t sb[$];
    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;
    bit exp_done = 1'b0;

    frame_renderer dut (
        .CLOCK_50      (clk),
        .reset         (reset),
        .start         (start),
        .scroll_offset (scroll_offset),
        .rom_addr      (rom_addr),
        .rom_data      (rom_data),
        .x             (x),
        .y             (y),
        .colour        (colour),
        .plot          (plot),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    // ROM: data = addr[2:0], one cycle late; rom_a2 is the address behind the current plot.
    always @(posedge clk) begin
        rom_data <= rom_addr[2:0];
        rom_a1   <= rom_addr;
        rom_a2   <= rom_a1;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Whole-frame reference: source row = (y + offset) mod rows, colour = low address bits.
    task automatic push_frame(input int offs);
        int o;
        int a;
        pix_t p;
        o = offs % YS;
        for (int yy = 0; yy < YS; yy++) begin
            for (int xx = 0; xx < XS; xx++) begin
                a = ((yy + o) % YS) * XS + xx;
                p.x      = 8'(xx);
                p.y      = 7'(yy);
                p.addr   = 15'(a);
                p.colour = 3'(a % 8);
                p.last   = (yy == YS - 1) && (xx == XS - 1);
                sb.push_back(p);
            end
        end
    endtask

    // Monitor: pops the scoreboard on every plot beat and polices done pulses.
    always @(negedge clk) begin
        pix_t e;
        if (!reset) begin
            if (done) begin
                done_cnt++;
                check("done_expected", 1, int'(exp_done));
                check("done_busy_low", int'(busy), 0);
                check("done_plot_low", int'(plot), 0);
            end else if (exp_done) begin
                check("done_missing", 0, 1);
            end
            exp_done = 1'b0;
            if (plot) begin
                if (sb.size() == 0) begin
                    check("plot_unexpected", 1, 0);
                end else begin
                    e = sb.pop_front();
                    n_checks++;
                    if (x !== e.x || y !== e.y || rom_a2 !== e.addr || colour !== e.colour) begin
                        n_errors++;
                        $display("FAIL pixel: got x=%0d y=%0d addr=%0d colour=%0d, expected x=%0d y=%0d addr=%0d colour=%0d",
                                 x, y, rom_a2, colour, e.x, e.y, e.addr, e.colour);
                    end
                    if (e.last) exp_done = 1'b1;
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge just after the accepting edge T.
    task automatic launch(input logic [6:0] offs);
        scroll_offset = offs;
        start = 1'b1;
        push_frame(int'(offs));
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", int'(busy), 1);
    endtask

    // Runs the rest of a frame counting samples after edge T; returns on the done cycle.
    task automatic finish_frame(input bit extra);
        int k = 0;
        int first_k = -1;
        int done_k = -1;
        int plots = 0;
        while (done_k < 0 && k < 20000) begin
            @(negedge clk);
            k++;
            start = 1'b0;
            if (plot) begin
                plots++;
                if (first_k < 0) first_k = k;
            end
            if (done) done_k = k;
            if (k == 50) scroll_offset = 7'($urandom_range(0, 127));
            if (extra && (k == 100 || k == 19000)) start = 1'b1;
        end
        start = 1'b0;
        check("frame_timeout", int'(done_k >= 0), 1);
        check("first_plot_cycle", first_k, 2);
        check("plot_count", plots, NPIX);
        check("done_cycle", done_k, NPIX + 2);
        check("scoreboard_drained", sb.size(), 0);
    endtask

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int dc;
        int plots;
        int k;
        logic [6:0] r_off;

        repeat (3) @(negedge clk);
        check("rst_rom_addr", int'(rom_addr), 0);
        check("rst_x", int'(x), 0);
        check("rst_y", int'(y), 0);
        check("rst_colour", int'(colour), 0);
        check("rst_plot", int'(plot), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Offset 0 frame, then offset 5 started on the done cycle.
        launch(7'd0);
        finish_frame(1'b0);
        launch(7'd5);
        finish_frame(1'b0);
        @(negedge clk);
        check("single_done_pulse", int'(done), 0);

        // Offset 125 folds to 5; extra starts mid-frame must be ignored.
        dc = done_cnt;
        launch(7'd125);
        finish_frame(1'b1);
        @(negedge clk);
        check("done_count_extra_starts", done_cnt - dc, 1);
        check("idle_busy", int'(busy), 0);

        // Reset during the 1000th plot beat.
        r_off = 7'($urandom_range(0, 127));
        launch(r_off);
        plots = 0;
        k = 0;
        while (plots < 1000 && k < 2000) begin
            @(negedge clk);
            k++;
            if (plot) plots++;
        end
        check("reach_1000_plots", plots, 1000);
        reset = 1'b1;
        @(posedge clk);
        sb.delete();
        exp_done = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        check("rst_mid_plot", int'(plot), 0);
        check("rst_mid_busy", int'(busy), 0);
        check("rst_mid_done", int'(done), 0);
        dc = done_cnt;
        repeat (5) @(negedge clk);
        check("no_done_after_reset", done_cnt - dc, 0);

        r_off = 7'($urandom_range(0, 127));
        launch(r_off);
        finish_frame(1'b0);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
